// File: rtl/md_seq.sv
// Iterative radix-2 multiply/divide sequencer owning the EX-stage HI/LO pair.
// Latency: WIDTH+1 cycles from accepted start to HI/LO update (done pulse).
// Backpressure: busy stalls the issuer; start/we while busy are ignored.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start, op       launch mult(00)/multu(01)/div(10)/divu(11)
//   d1, d2          multiplicand/dividend (also mthi/mtlo data), multiplier/divisor
//   we, hilo_sel    mthi/mtlo write strobe and target (0 HI, 1 LO)
//   cancel          interrupt flush of the EX instruction; blocks start/we in IDLE
//   busy            operation in progress, decoded from the state register
//   done, dz        one-cycle pulses: HI/LO updated, divide by zero
//   hi, lo          HI/LO registers
module md_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             we,
  input  logic             hilo_sel,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [1:0]      op_r;
  logic            sign_a;     // d1 negative (signed ops only)
  logic            sign_b;     // d2 negative (signed ops only)
  logic            zero_div;   // divisor was zero
  // opnd holds the operand added/subtracted each step: |d1| for mult, |d2| for div.
  // acc_lo starts as the operand that is shifted out: |d2| for mult, |d1| for div.
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             d1_neg, d2_neg;
  logic [WIDTH-1:0] d1_mag, d2_mag;
  logic             is_div, is_signed;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shf;
  logic [WIDTH-1:0] div_dif;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             accept;

  assign busy      = (state != IDLE);
  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];
  assign accept    = (state == IDLE) && start && !cancel;

  always_comb begin
    d1_neg  = ~op[0] & d1[WIDTH-1];
    d2_neg  = ~op[0] & d2[WIDTH-1];
    d1_mag  = d1_neg ? -d1 : d1;
    d2_mag  = d2_neg ? -d2 : d2;

    // Shift-add step: conditional add into the upper half, carry kept for the shift.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    // Restoring-divide step: bring in the next dividend bit and trial-subtract.
    // The difference is only kept when it fits, so WIDTH bits suffice.
    div_shf = {acc_hi, acc_lo[WIDTH-1]};
    div_ge  = (div_shf >= {1'b0, opnd});
    div_dif = div_shf[WIDTH-1:0] - opnd;

    prod     = {acc_hi, acc_lo};
    prod_fix = (is_signed && (sign_a ^ sign_b)) ? -prod : prod;
    quo_fix  = (is_signed && (sign_a ^ sign_b)) ? -acc_lo : acc_lo;
    // Remainder follows the dividend's sign.
    rem_fix  = (is_signed && sign_a) ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      op_r     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      zero_div <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_r     <= op;
            sign_a   <= d1_neg;
            sign_b   <= d2_neg;
            zero_div <= (d2 == '0);
            opnd     <= op[1] ? d2_mag : d1_mag;
            acc_lo   <= op[1] ? d1_mag : d2_mag;
            acc_hi   <= '0;
            count    <= '0;
            state    <= RUN;
          end else if (we && !cancel && !start) begin
            // A start in the same cycle (even a cancelled one) drops the write.
            if (hilo_sel) lo <= d1;
            else          hi <= d1;
          end
        end
        RUN: begin
          if (is_div) begin
            acc_hi <= div_ge ? div_dif : div_shf[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          if (count == LAST) state <= FIX;
          else               count <= count + CW'(1);
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (!zero_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end
          done  <= 1'b1;
          dz    <= is_div & zero_div;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_seq.sv
module tb_md_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] d1, d2;
  logic         we;
  logic         hilo_sel;
  logic         cancel;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;

  md_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .d1(d1), .d2(d2),
    .we(we), .hilo_sel(hilo_sel), .cancel(cancel),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation at a negedge and follow busy until it drops.
  // Returns with the bench at the negedge where busy first reads 0.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int nbusy);
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb;
    logic [W-1:0] lo_prev;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

    rst = 1'b0; start = 1'b0; op = 2'b00; d1 = '0; d2 = '0;
    we = 1'b0; hilo_sel = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset dz",   {63'd0, dz},   64'd0);
    chk("reset hi",   {32'd0, hi},   64'd0);
    chk("reset lo",   {32'd0, lo},   64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].d1, vecs[i].d2, nb);
      chk($sformatf("v%0d busy cycles", i), 64'(nb), 64'd33);
      chk($sformatf("v%0d done", i), {63'd0, done}, 64'd1);
      chk($sformatf("v%0d dz", i),   {63'd0, dz},   64'd0);
      chk($sformatf("v%0d hi", i),   {32'd0, hi},   {32'd0, vecs[i].hi});
      chk($sformatf("v%0d lo", i),   {32'd0, lo},   {32'd0, vecs[i].lo});
      @(negedge clk);
      chk($sformatf("v%0d done one cycle", i), {63'd0, done}, 64'd0);
    end

    // Preload HI/LO, then divide by zero leaves them untouched
    we = 1'b1; hilo_sel = 1'b0; d1 = 32'h11;
    @(negedge clk);
    hilo_sel = 1'b1; d1 = 32'h22;
    @(negedge clk);
    we = 1'b0;
    chk("preload hi", {32'd0, hi}, 64'h11);
    chk("preload lo", {32'd0, lo}, 64'h22);
    chk("we no done", {63'd0, done}, 64'd0);
    run_op(2'b11, 32'd55, 32'd0, nb);
    chk("dz busy cycles", 64'(nb), 64'd33);
    chk("dz done", {63'd0, done}, 64'd1);
    chk("dz pulse", {63'd0, dz}, 64'd1);
    chk("dz hi kept", {32'd0, hi}, 64'h11);
    chk("dz lo kept", {32'd0, lo}, 64'h22);
    @(negedge clk);
    chk("dz one cycle", {63'd0, dz}, 64'd0);

    // Start with cancel is dropped
    start = 1'b1; cancel = 1'b1; op = 2'b01; d1 = 32'd3; d2 = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel start busy", {63'd0, busy}, 64'd0);
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy || done) nb++;
      @(negedge clk);
    end
    chk("cancel start no activity", 64'(nb), 64'd0);

    // mtlo with cancel dropped, without cancel applied
    we = 1'b1; hilo_sel = 1'b1; d1 = 32'hABCD; cancel = 1'b1;
    @(negedge clk);
    we = 1'b0; cancel = 1'b0;
    chk("we cancel lo kept", {32'd0, lo}, 64'h22);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("we lo written", {32'd0, lo}, 64'hABCD);
    chk("we hi kept", {32'd0, hi}, 64'h11);

    // mult 6*7 with a second start, a we and a cancel landing mid-operation
    start = 1'b1; op = 2'b00; d1 = 32'd6; d2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      start    = (nb == 10);
      we       = (nb == 12);
      cancel   = (nb == 15);
      hilo_sel = 1'b0;
      if (nb == 10) begin op = 2'b11; d1 = 32'd100; d2 = 32'd7; end
      if (nb == 12) d1 = 32'hDEAD;
      @(negedge clk);
    end
    start = 1'b0; we = 1'b0; cancel = 1'b0;
    chk("mid busy cycles", 64'(nb), 64'd33);
    chk("mid done", {63'd0, done}, 64'd1);
    chk("mid hi", {32'd0, hi}, 64'd0);
    chk("mid lo", {32'd0, lo}, 64'd42);
    @(negedge clk);
    chk("mid no second op", {63'd0, busy}, 64'd0);

    // we together with start: start wins, write dropped
    lo_prev = lo;
    start = 1'b1; op = 2'b01; d1 = 32'd3; d2 = 32'd4;
    we = 1'b1; hilo_sel = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    chk("we+start lo kept", {32'd0, lo}, {32'd0, lo_prev});
    chk("we+start busy", {63'd0, busy}, 64'd1);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("we+start lo", {32'd0, lo}, 64'd12);

    // Asynchronous reset in the middle of a divide
    start = 1'b1; op = 2'b11; d1 = 32'd1000; d2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre-reset busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async rst busy", {63'd0, busy}, 64'd0);
    chk("async rst hi", {32'd0, hi}, 64'd0);
    chk("async rst lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset done", {63'd0, done}, 64'd0);
    run_op(2'b00, 32'd6, 32'd7, nb);
    chk("post-reset busy cycles", 64'(nb), 64'd33);
    chk("post-reset hi", {32'd0, hi}, 64'd0);
    chk("post-reset lo", {32'd0, lo}, 64'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/md_seq.md
Name: md_seq

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair of the pipeline's EX stage.
- Accepts one mult/multu/div/divu start per operation and runs a radix-2 shift-add / restoring-divide loop.
- Exposes busy for the hazard unit's stall decision, and handles mthi/mtlo writes.
- Honours the pipeline's interrupt-flush cancel for the instruction currently in EX.

Parameters:
WIDTH, 32, operand and HI/LO width; an operation takes WIDTH+1 cycles.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin operation selected by op; sampled at clk edge
op  in  2  00 mult, 01 multu, 10 div, 11 divu
d1  in  WIDTH  multiplicand / dividend; also mthi/mtlo write data
d2  in  WIDTH  multiplier / divisor
we  in  1  mthi/mtlo write strobe
hilo_sel  in  1  target of we: 0 HI, 1 LO
cancel  in  1  interrupt flush of EX-stage instruction
busy  out  1  operation in progress (registered)
done  out  1  one-cycle pulse, HI/LO just updated by an operation
dz  out  1  one-cycle pulse with done when a div/divu had d2==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
Reset and states
- Reset is asynchronous and active-low, any time, including mid-operation. It forces state IDLE, iteration counter 0, hi=0, lo=0, busy=0, done=0, dz=0. Partial results are discarded.
- States: IDLE, RUN, FIX. busy = (state != IDLE), taken from the state register.

Timing
- Edge E0, IDLE, start=1, cancel=0: latch op, |d1|, |d2| (magnitudes for signed ops), the sign flags, and d2==0. Clear the accumulator and set count=0. Go to RUN.
- RUN: one iteration per edge.
  - mult: if multiplier LSB is set, add multiplicand to the upper accumulator, then shift right 1.
  - div: shift the remainder/quotient left 1; trial-subtract the divisor; keep the result if non-negative and set the quotient bit.
  - At the edge where count reaches WIDTH-1 (edge E_WIDTH), go to FIX.
- FIX, edge E(WIDTH+1):
  - Apply sign correction. Signed mult negates the 2*WIDTH product if the signs differ. Signed div negates the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo: mult gives hi=product[2W-1:W], lo=product[W-1:0]; div gives lo=quotient, hi=remainder.
  - Go to IDLE. done=1 for exactly one cycle.
- busy is high for exactly WIDTH+1 cycles (33 at default), from E0 to E(WIDTH+1). hi/lo show the new values in the cycle after E(WIDTH+1).

Divide by zero
- hi/lo are left unchanged. The full WIDTH+1 latency is still taken.
- dz pulses together with done.

Boundary conditions
- Signed div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- start while busy: ignored; the in-flight operation is unaffected. The hazard unit never issues this, but it is defined here.
- start with cancel=1 in the same cycle: ignored; stays IDLE, busy stays 0.
- cancel during RUN/FIX: no effect. An issued operation always completes.
- we=1, cancel=0, IDLE, and start not accepted in this cycle: at the edge, hi or lo (per hilo_sel) <= d1. Visible the next cycle. done and dz are not asserted.
- we with cancel=1, or we while busy: ignored.
- we and start together in IDLE: start wins; the write is dropped.
- Hazard unit stalls on (busy | start); md_seq does not drive start-qualified busy combinationally.

Test Plan:
- mult d1=0xFFFFFFFD (-3), d2=5 -> busy high 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu d1=0xFFFFFFFF, d2=2 -> hi=0x00000001, lo=0xFFFFFFFE. div d1=0xFFFFFFF9 (-7), d2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- Preload hi=0x11, lo=0x22 via we; then divu d2=0 -> after 33 cycles dz=1 and done=1 in the same cycle; hi=0x11, lo=0x22 unchanged.
- start with cancel=1 -> busy stays 0, no done. we hilo_sel=1 d1=0xABCD with cancel=1 -> lo unchanged. Same with cancel=0 -> lo=0xABCD next cycle.
- Second start at cycle 10 of a mult -> ignored; first result correct at cycle 33. we mid-operation -> hi/lo not written by the we.
- Assert rst low at cycle 15 of a div -> hi=lo=0, busy=0 immediately (asynchronous). After release, a new mult 6*7 -> lo=42, hi=0.
